// File: rtl/vga_bus_pkg.sv
// Shared constants for the VGA frame-buffer bus: register map, frame size
// and the rectangle-fill FSM encoding.
package vga_bus_pkg;

    localparam logic [7:0] VGA_BASE_ADDR = 8'hB0;
    localparam logic [7:0] REG_OFS_X     = 8'd0;
    localparam logic [7:0] REG_OFS_Y     = 8'd1;
    localparam logic [7:0] REG_OFS_PIX   = 8'd2;
    localparam logic [7:0] REG_OFS_CTRL  = 8'd3;

    localparam int FRAME_W = 160;
    localparam int FRAME_H = 120;

    localparam logic [7:0] MAX_X = 8'(FRAME_W - 1);
    localparam logic [6:0] MAX_Y = 7'(FRAME_H - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_SET_Y,
        ST_SET_X,
        ST_WR_PIX,
        ST_GAP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/vga_rect_fill_master_if.sv
// Initiator-side bus bundle between the fill engine and the bus arbiter.
interface vga_rect_fill_master_if;

    logic       BUS_REQ;
    logic       BUS_GNT;
    logic [7:0] BUS_ADDR_OUT;
    logic       BUS_WE_OUT;
    logic       BUS_DATA_OE;

    modport master (
        output BUS_REQ,
        output BUS_ADDR_OUT,
        output BUS_WE_OUT,
        output BUS_DATA_OE,
        input  BUS_GNT
    );

    modport slave (
        input  BUS_REQ,
        input  BUS_ADDR_OUT,
        input  BUS_WE_OUT,
        input  BUS_DATA_OE,
        output BUS_GNT
    );

endinterface

// File: rtl/rect_scan_counter.sv
// Row-major pixel walker: holds the current column/row and flags the end of
// a row and the final pixel of the rectangle.
module rect_scan_counter (
    input  logic       clk,
    input  logic       load,
    input  logic       step,
    input  logic [7:0] load_x,
    input  logic [6:0] load_y,
    input  logic [7:0] x_first,
    input  logic [7:0] x_last,
    input  logic [6:0] y_last,
    output logic [7:0] cx,
    output logic [6:0] cy,
    output logic       row_end,
    output logic       last
);

    logic [7:0] cx_q, cx_d;
    logic [6:0] cy_q, cy_d;

    assign row_end = (cx_q == x_last);
    assign last    = row_end && (cy_q == y_last);
    assign cx      = cx_q;
    assign cy      = cy_q;

    // Limits are pre-clamped, so incrementing never wraps past the frame edge.
    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (load) begin
            cx_d = load_x;
            cy_d = load_y;
        end else if (step) begin
            if (row_end) begin
                cx_d = x_first;
                cy_d = cy_q + 7'd1;
            end else begin
                cx_d = cx_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        cx_q <= cx_d;
        cy_q <= cy_d;
    end

endmodule

// File: rtl/vga_rect_fill_master.sv
// Rectangle-fill bus master: walks a clamped rectangle row-major and writes
// each pixel into the VGA frame buffer through its X/Y/pixel registers.
module vga_rect_fill_master
    import vga_bus_pkg::*;
#(
    parameter logic [7:0] VGABaseAddress = VGA_BASE_ADDR,
    parameter logic [7:0] MaxX           = MAX_X,
    parameter logic [6:0] MaxY           = MAX_Y
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   START,
    input  logic [7:0]             X0,
    input  logic [6:0]             Y0,
    input  logic [7:0]             X1,
    input  logic [6:0]             Y1,
    input  logic                   PIXEL,
    output logic                   BUSY,
    output logic                   DONE,
    vga_rect_fill_master_if.master bus,
    inout  wire  [7:0]             BUS_DATA
);

    function automatic logic [7:0] clamp_x(input logic [7:0] x);
        return (x > MaxX) ? MaxX : x;
    endfunction

    function automatic logic [6:0] clamp_y(input logic [6:0] y);
        return (y > MaxY) ? MaxY : y;
    endfunction

    state_t     state_q, state_d;
    logic [7:0] x0_q, x0_d, x1_q, x1_d;
    logic [6:0] y0_q, y0_d, y1_q, y1_d;
    logic       pixel_q, pixel_d;

    logic       accept, empty;
    logic       cnt_step;
    logic [7:0] cx;
    logic [6:0] cy;
    logic       row_end, last;

    logic       req, we, busy, done;
    logic [7:0] addr, wdata;

    // BUSY is already low in DONE, so a new START may be taken there too.
    assign accept = START && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign empty  = (x0_q > x1_q) || (y0_q > y1_q) || (x0_q > MaxX) || (y0_q > MaxY);

    always_comb begin
        x0_d    = x0_q;
        y0_d    = y0_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        pixel_d = pixel_q;
        if (accept) begin
            x0_d    = X0;
            y0_d    = Y0;
            x1_d    = clamp_x(X1);
            y1_d    = clamp_y(Y1);
            pixel_d = PIXEL;
        end
    end

    always_ff @(posedge CLK) begin
        x0_q    <= x0_d;
        y0_q    <= y0_d;
        x1_q    <= x1_d;
        y1_q    <= y1_d;
        pixel_q <= pixel_d;
    end

    rect_scan_counter u_scan (
        .clk     (CLK),
        .load    (accept),
        .step    (cnt_step),
        .load_x  (X0),
        .load_y  (Y0),
        .x_first (x0_q),
        .x_last  (x1_q),
        .y_last  (y1_q),
        .cx      (cx),
        .cy      (cy),
        .row_end (row_end),
        .last    (last)
    );

    always_ff @(posedge CLK) begin
        if (RESET) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        req      = 1'b0;
        we       = 1'b0;
        addr     = 8'h00;
        wdata    = 8'h00;
        busy     = 1'b1;
        done     = 1'b0;
        cnt_step = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (accept) state_d = ST_REQ;
            end
            // Emptiness is judged on the latched, clamped operands.
            ST_REQ: begin
                if (empty) begin
                    state_d = ST_DONE;
                end else begin
                    req = 1'b1;
                    if (bus.BUS_GNT) state_d = ST_SET_Y;
                end
            end
            ST_SET_Y: begin
                req     = 1'b1;
                we      = 1'b1;
                addr    = VGABaseAddress + REG_OFS_Y;
                wdata   = {1'b0, cy};
                state_d = ST_SET_X;
            end
            ST_SET_X: begin
                req     = 1'b1;
                we      = 1'b1;
                addr    = VGABaseAddress + REG_OFS_X;
                wdata   = cx;
                state_d = ST_WR_PIX;
            end
            ST_WR_PIX: begin
                req     = 1'b1;
                we      = 1'b1;
                addr    = VGABaseAddress + REG_OFS_PIX;
                wdata   = {7'b0, pixel_q};
                state_d = ST_GAP;
            end
            // After a lost grant the processor may have touched X/Y, so resume at SET_Y.
            ST_GAP: begin
                req = 1'b1;
                if (last) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_step = 1'b1;
                    if (!bus.BUS_GNT) state_d = ST_REQ;
                    else if (row_end) state_d = ST_SET_Y;
                    else              state_d = ST_SET_X;
                end
            end
            ST_DONE: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = accept ? ST_REQ : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign BUSY             = busy;
    assign DONE             = done;
    assign bus.BUS_REQ      = req;
    assign bus.BUS_WE_OUT   = we;
    assign bus.BUS_ADDR_OUT = addr;
    assign bus.BUS_DATA_OE  = we;
    assign BUS_DATA         = we ? wdata : 8'hzz;

endmodule

// File: tb/tb_vga_rect_fill_master.sv
// Bench for the rectangle-fill master: table vectors, directed corner cases and
// random fills with grant jitter, checked against a pixel-list model.
module tb_vga_rect_fill_master;

    localparam int BASE = 176;
    localparam int FW   = 160;
    localparam int FH   = 120;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       START = 1'b0;
    logic [7:0] X0 = 8'd0, X1 = 8'd0;
    logic [6:0] Y0 = 7'd0, Y1 = 7'd0;
    logic       PIXEL = 1'b0;
    logic       BUSY, DONE;
    wire  [7:0] BUS_DATA;
    logic       gnt_main = 1'b1;
    logic       gnt_jit  = 1'b1;
    bit         jit_en   = 1'b0;

    vga_rect_fill_master_if bus();
    assign bus.BUS_GNT = gnt_main & gnt_jit;

    vga_rect_fill_master dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .START    (START),
        .X0       (X0),
        .Y0       (Y0),
        .X1       (X1),
        .Y1       (Y1),
        .PIXEL    (PIXEL),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .bus      (bus),
        .BUS_DATA (BUS_DATA)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0, n_fail = 0;
    int n_busy, n_req, n_done, n_oe, done_cyc, first_we, start_cyc;
    int wr_q[$], pix_q[$], exp_wr[$], exp_pix[$];
    int exp_lat;
    int px = 0, py = 0;
    bit prev_pix = 1'b0;
    bit fb [FW*FH];

    typedef struct { int x0, y0, x1, y1, pix, n_wr, lat; } vec_t;
    vec_t tbl [8];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int enc(input int x, input int y, input int p);
        return (y << 9) | (x << 1) | p;
    endfunction

    // Peripheral view of the bus: X/Y registers plus the frame buffer.
    initial forever begin
        @(negedge CLK);
        if (BUSY) n_busy++;
        if (bus.BUS_REQ) n_req++;
        if (bus.BUS_DATA_OE) n_oe++;
        if (DONE) begin n_done++; done_cyc = cyc; end
        if (prev_pix) check("gap_after_pixel", int'(bus.BUS_WE_OUT), 0);
        if (bus.BUS_WE_OUT) begin
            if (first_we < 0) first_we = cyc;
            check("we_with_gnt", int'(bus.BUS_GNT), 1);
            check("we_drives_data", int'(bus.BUS_DATA_OE), 1);
            check("addr_in_window", int'(bus.BUS_ADDR_OUT >= 8'hB0 && bus.BUS_ADDR_OUT <= 8'hB2), 1);
            wr_q.push_back((int'(bus.BUS_ADDR_OUT) << 8) | int'(BUS_DATA));
            if (bus.BUS_ADDR_OUT == 8'hB0) begin
                px = int'(BUS_DATA);
                check("x_in_range", int'(px < FW), 1);
            end else if (bus.BUS_ADDR_OUT == 8'hB1) begin
                py = int'(BUS_DATA);
                check("y_in_range", int'(py < FH), 1);
            end else if (bus.BUS_ADDR_OUT == 8'hB2) begin
                pix_q.push_back(enc(px, py, int'(BUS_DATA[0])));
                if (px < FW && py < FH) fb[py*FW + px] = BUS_DATA[0];
            end
        end
        prev_pix = bus.BUS_WE_OUT && (bus.BUS_ADDR_OUT == 8'hB2);
    end

    // Arbiter that sometimes takes the bus away right after a pixel write.
    initial forever begin
        @(negedge CLK);
        if (jit_en && bus.BUS_WE_OUT && bus.BUS_ADDR_OUT == 8'hB2 && $urandom_range(0, 2) == 0) begin
            @(posedge CLK); #1;
            gnt_jit = 1'b0;
            repeat ($urandom_range(1, 4)) @(posedge CLK);
            #1;
            gnt_jit = 1'b1;
        end
    end

    function automatic void model(input int x0, input int y0, input int x1, input int y1, input int pix);
        int xe = (x1 > FW-1) ? FW-1 : x1;
        int ye = (y1 > FH-1) ? FH-1 : y1;
        exp_wr.delete();
        exp_pix.delete();
        exp_lat = 2;
        if (x0 > xe || y0 > ye) return;
        for (int y = y0; y <= ye; y++) begin
            exp_wr.push_back(((BASE+1) << 8) | y);
            for (int x = x0; x <= xe; x++) begin
                exp_wr.push_back((BASE << 8) | x);
                exp_wr.push_back(((BASE+2) << 8) | pix);
                exp_pix.push_back(enc(x, y, pix));
            end
        end
        exp_lat = 2 + (ye - y0 + 1) * (1 + 3 * (xe - x0 + 1));
    endfunction

    function automatic int count_diff(input int a[$], input int b[$]);
        int n = 0;
        for (int i = 0; i < a.size() || i < b.size(); i++)
            if (i >= a.size() || i >= b.size() || a[i] != b[i]) n++;
        return n;
    endfunction

    task automatic start_fill(input int x0, input int y0, input int x1, input int y1, input int pix);
        @(posedge CLK); #1;
        n_busy = 0; n_req = 0; n_done = 0; n_oe = 0; first_we = -1; done_cyc = -1;
        wr_q.delete(); pix_q.delete();
        X0 = 8'(x0); Y0 = 7'(y0); X1 = 8'(x1); Y1 = 7'(y1); PIXEL = 1'(pix);
        START = 1'b1;
        start_cyc = cyc;
        @(posedge CLK); #1;
        START = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (n_done == 0 && n < budget) begin @(posedge CLK); n++; end
        check({tag, " done_within_budget"}, int'(n_done > 0), 1);
    endtask

    task automatic wait_pixels(input int cnt, input int budget);
        int n = 0;
        while (pix_q.size() < cnt && n < budget) begin @(posedge CLK); n++; end
        check("pixels_before_event", int'(pix_q.size() >= cnt), 1);
    endtask

    task automatic verify(input string tag, input bit exact);
        int lat;
        repeat (3) @(posedge CLK);
        lat = done_cyc - start_cyc;
        check({tag, " done_pulses"}, n_done, 1);
        check({tag, " busy_cycles"}, n_busy, lat - 1);
        check({tag, " pixel_count"}, pix_q.size(), exp_pix.size());
        check({tag, " pixel_order_diffs"}, count_diff(pix_q, exp_pix), 0);
        if (exact) begin
            check({tag, " latency"}, lat, exp_lat);
            check({tag, " write_seq_diffs"}, count_diff(wr_q, exp_wr), 0);
            check({tag, " data_drive_cycles"}, n_oe, exp_wr.size());
            check({tag, " req_cycles"}, n_req, (exp_wr.size() > 0) ? exp_lat - 1 : 0);
            if (exp_wr.size() > 0) begin
                check({tag, " first_write_delay"}, first_we - start_cyc, 2);
                check({tag, " done_after_first_write"}, done_cyc - first_we, exp_lat - 2);
            end
        end else begin
            check({tag, " latency_min"}, int'(lat >= exp_lat), 1);
        end
    endtask

    initial begin
        int lat, ones, x0, y0, x1, y1, pix;

        tbl[0] = '{2, 3, 4, 3, 1, 7, 12};
        tbl[1] = '{10, 0, 5, 5, 1, 0, 2};
        tbl[2] = '{158, 118, 200, 127, 1, 10, 16};
        tbl[3] = '{5, 5, 5, 5, 0, 3, 6};
        tbl[4] = '{0, 120, 3, 127, 1, 0, 2};
        tbl[5] = '{160, 0, 200, 0, 1, 0, 2};
        tbl[6] = '{7, 2, 9, 4, 0, 21, 32};
        tbl[7] = '{0, 10, 0, 5, 1, 0, 2};

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst busy", int'(BUSY), 0);
        check("rst done", int'(DONE), 0);
        check("rst req", int'(bus.BUS_REQ), 0);
        check("rst we", int'(bus.BUS_WE_OUT), 0);
        check("rst addr", int'(bus.BUS_ADDR_OUT), 0);
        check("rst data_oe", int'(bus.BUS_DATA_OE), 0);
        #1 RESET = 1'b0;

        for (int i = 0; i < 8; i++) begin
            model(tbl[i].x0, tbl[i].y0, tbl[i].x1, tbl[i].y1, tbl[i].pix);
            start_fill(tbl[i].x0, tbl[i].y0, tbl[i].x1, tbl[i].y1, tbl[i].pix);
            wait_done($sformatf("vec%0d", i), 200);
            verify($sformatf("vec%0d", i), 1'b1);
            lat = done_cyc - start_cyc;
            check($sformatf("vec%0d table_latency", i), lat, tbl[i].lat);
            check($sformatf("vec%0d table_writes", i), wr_q.size(), tbl[i].n_wr);
        end

        // Grant dropped for 5 cycles in the gap after pixel (3,3).
        model(2, 3, 4, 3, 1);
        exp_wr = '{(BASE+1)<<8 | 3, BASE<<8 | 2, (BASE+2)<<8 | 1, BASE<<8 | 3, (BASE+2)<<8 | 1,
                   (BASE+1)<<8 | 3, BASE<<8 | 4, (BASE+2)<<8 | 1};
        exp_lat = 18;
        start_fill(2, 3, 4, 3, 1);
        wait_pixels(2, 20);
        #1 gnt_main = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("drop req_held", int'(bus.BUS_REQ), 1);
        check("drop no_write", int'(bus.BUS_WE_OUT), 0);
        check("drop busy", int'(BUSY), 1);
        repeat (4) @(posedge CLK);
        #1 gnt_main = 1'b1;
        wait_done("drop", 100);
        verify("drop", 1'b1);

        // START while busy must be ignored.
        model(20, 20, 22, 21, 1);
        start_fill(20, 20, 22, 21, 1);
        repeat (4) @(posedge CLK);
        #1;
        X0 = 8'd0; Y0 = 7'd0; X1 = 8'd5; Y1 = 7'd5; PIXEL = 1'b0; START = 1'b1;
        @(posedge CLK); #1 START = 1'b0;
        wait_done("busy_start", 100);
        verify("busy_start", 1'b1);
        check("busy_start idle_after", int'(BUSY), 0);

        // Reset in the middle of a row, then a single-pixel fill.
        start_fill(0, 5, 20, 5, 1);
        wait_pixels(4, 40);
        #1 RESET = 1'b1;
        @(posedge CLK); #1 RESET = 1'b0;
        @(negedge CLK);
        check("midrst busy", int'(BUSY), 0);
        check("midrst done", int'(DONE), 0);
        check("midrst req", int'(bus.BUS_REQ), 0);
        check("midrst we", int'(bus.BUS_WE_OUT), 0);
        check("midrst addr", int'(bus.BUS_ADDR_OUT), 0);
        check("midrst data_oe", int'(bus.BUS_DATA_OE), 0);
        repeat (10) @(posedge CLK);
        check("midrst no_done", n_done, 0);
        model(0, 0, 0, 0, 1);
        start_fill(0, 0, 0, 0, 1);
        wait_done("after_rst", 50);
        verify("after_rst", 1'b1);

        // Random rectangles with an arbiter that steals the bus.
        jit_en = 1'b1;
        for (int i = 0; i < 25; i++) begin
            x0 = $urandom_range(0, 165);
            y0 = $urandom_range(0, 123);
            x1 = ($urandom_range(0, 7) == 0) ? x0 - 1 : x0 + $urandom_range(0, 3);
            y1 = ($urandom_range(0, 7) == 0) ? y0 - 1 : y0 + $urandom_range(0, 3);
            if (x1 < 0) x1 = 0;
            if (y1 < 0) y1 = 0;
            if (y1 > 127) y1 = 127;
            pix = $urandom_range(0, 1);
            model(x0, y0, x1, y1, pix);
            start_fill(x0, y0, x1, y1, pix);
            wait_done($sformatf("rnd%0d", i), exp_lat * 4 + 100);
            verify($sformatf("rnd%0d", i), 1'b0);
        end
        jit_en = 1'b0;
        repeat (6) @(posedge CLK);

        // Full-screen clear over a frame buffer preset to all ones.
        for (int i = 0; i < FW*FH; i++) fb[i] = 1'b1;
        model(0, 0, 159, 119, 0);
        start_fill(0, 0, 159, 119, 0);
        wait_done("full", 60000);
        verify("full", 1'b1);
        check("full latency_const", done_cyc - start_cyc, 57722);
        ones = 0;
        for (int i = 0; i < FW*FH; i++) if (fb[i]) ones++;
        check("full fb_ones", ones, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
